// File: rtl/matrix_convolution_strided.sv
// matrix_convolution_strided: memory-mapped strided 2-D convolution engine with a filter cache.
// The filter is fetched once per job, then every output is accumulated and written back.
// Parameters are read from a block in memory; results are written in row-major order.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   enable          a rising edge starts a job while idle
//   mem_opdone      memory completes the current transaction this cycle
//   data_i          read data, valid with mem_opdone
//   data_o, addr_o  write data and word address
//   mem_operation   00 none, 01 read, 11 write
//   done, error     job finished (held) and bad-parameter flag
//   busy            high from start until done
// Optional build macro MATCONV_SATURATE_EN: clamp the accumulator to the DATA_W range of the
// active mode before writing instead of truncating it.
module matrix_convolution_strided #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int unsigned PARAM_BASE = 0,
    parameter int MAX_TAPS = 16,
    parameter int ACC_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mem_opdone,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        mem_operation,
    output logic              done,
    output logic              error,
    output logic              busy
);
    localparam int IW = MAX_TAPS > 1 ? $clog2(MAX_TAPS) : 1;
    localparam int XW = DATA_W + 2;

    typedef enum logic [3:0] {
        S_DONE, S_FETCH, S_CHECK, S_LOAD, S_ROW, S_COL, S_MAC_READ, S_MAC, S_WRITE
    } state_t;

    state_t state, next_state;
    logic last_enable;
    logic [2:0] pidx;
    logic [DATA_W-1:0] wa, ha, wf, hf, sr, k, l, a_val;
    logic [1:0] mode;
    logic [IW-1:0] tap, fidx;
    logic [DATA_W-1:0] fcache [MAX_TAPS];
    logic [XW-1:0] r, c;
    logic [ACC_W-1:0] acc, ea, ef;
    logic [ADDR_W-1:0] wr_addr, ba, bf, br, a_addr;
    logic [2*DATA_W-1:0] taps;
    logic [DATA_W-1:0] s_eff, res;
    logic start, idle, xfer, bad, row_ok, col_ok, last_tap, last_l, last_k;

    assign start    = enable && !last_enable;
    assign idle     = mem_operation == 2'b00;
    assign xfer     = !idle && mem_opdone;
    assign s_eff    = sr == '0 ? DATA_W'(1) : sr;
    // Double-width product so huge filter dimensions cannot wrap past the tap limit.
    assign taps     = (2*DATA_W)'(wf) * (2*DATA_W)'(hf);
    assign bad      = wa == '0 || ha == '0 || wf == '0 || hf == '0 || wf > wa || hf > ha ||
                      taps > (2*DATA_W)'(MAX_TAPS);
    assign ba       = ADDR_W'(PARAM_BASE) + ADDR_W'(6);
    assign bf       = ba + ADDR_W'(wa * ha);
    assign br       = bf + ADDR_W'(taps);
    assign a_addr   = ba + ADDR_W'((r + XW'(k)) * XW'(wa)) + ADDR_W'(c + XW'(l));
    // Origins carry two extra bits so origin+size never overflows before the bound test.
    assign row_ok   = r + XW'(hf) <= XW'(ha);
    assign col_ok   = c + XW'(wf) <= XW'(wa);
    assign last_tap = tap == IW'(taps) - IW'(1);
    assign last_l   = l == wf - DATA_W'(1);
    assign last_k   = k == hf - DATA_W'(1);
    assign ea       = {{(ACC_W-DATA_W){a_val[DATA_W-1] & mode[0]}}, a_val};
    assign ef       = {{(ACC_W-DATA_W){fcache[fidx][DATA_W-1] & mode[0]}}, fcache[fidx]};

    always_comb begin
        res = acc[DATA_W-1:0];
`ifdef MATCONV_SATURATE_EN
        if (mode[0] && acc[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){acc[ACC_W-1]}})
            res = {acc[ACC_W-1], {(DATA_W-1){~acc[ACC_W-1]}}};
        else if (!mode[0] && |acc[ACC_W-1:DATA_W])
            res = '1;
`endif
        if (mode[1] && acc[ACC_W-1])
            res = '0;
    end

    always_ff @(posedge clk)
        state <= reset ? S_DONE : next_state;

    always_comb begin
        next_state = state;
        case (state)
            S_DONE:     next_state = start ? S_FETCH : S_DONE;
            S_FETCH:    next_state = xfer && pidx == 3'd5 ? S_CHECK : S_FETCH;
            S_CHECK:    next_state = bad ? S_DONE : S_LOAD;
            S_LOAD:     next_state = xfer && last_tap ? S_ROW : S_LOAD;
            S_ROW:      next_state = row_ok ? S_COL : S_DONE;
            S_COL:      next_state = col_ok ? S_MAC_READ : S_ROW;
            S_MAC_READ: next_state = xfer ? S_MAC : S_MAC_READ;
            S_MAC:      next_state = last_l && last_k ? S_WRITE : S_MAC_READ;
            S_WRITE:    next_state = xfer ? S_COL : S_WRITE;
            default:    next_state = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_enable   <= 1'b0;
            mem_operation <= 2'b00;
            addr_o        <= '0;
            data_o        <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            last_enable <= enable;
            if (xfer)
                mem_operation <= 2'b00;
            case (state)
                S_DONE: if (start) begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b1;
                    pidx  <= '0;
                end
                S_FETCH: if (idle) begin
                    mem_operation <= 2'b01;
                    addr_o        <= ADDR_W'(PARAM_BASE) + ADDR_W'(pidx);
                end else if (mem_opdone) begin
                    case (pidx)
                        3'd0:    wa <= data_i;
                        3'd1:    ha <= data_i;
                        3'd2:    wf <= data_i;
                        3'd3:    hf <= data_i;
                        3'd4:    sr <= data_i;
                        default: mode <= data_i[1:0];
                    endcase
                    pidx <= pidx + 3'd1;
                end
                S_CHECK: if (bad) begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    tap     <= '0;
                    acc     <= '0;
                    wr_addr <= br;
                end
                S_LOAD: if (idle) begin
                    mem_operation <= 2'b01;
                    addr_o        <= bf + ADDR_W'(tap);
                end else if (mem_opdone) begin
                    fcache[tap] <= data_i;
                    tap         <= tap + IW'(1);
                    r           <= '0;
                end
                S_ROW: if (row_ok) c <= '0; else begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                S_COL: if (col_ok) begin
                    k    <= '0;
                    l    <= '0;
                    fidx <= '0;
                end else
                    r <= r + XW'(s_eff);
                S_MAC_READ: if (idle) begin
                    mem_operation <= 2'b01;
                    addr_o        <= a_addr;
                end else if (mem_opdone)
                    a_val <= data_i;
                S_MAC: begin
                    acc  <= acc + ea * ef;
                    fidx <= fidx + IW'(1);
                    l    <= last_l ? '0 : l + DATA_W'(1);
                    k    <= last_l ? k + DATA_W'(1) : k;
                end
                S_WRITE: if (idle) begin
                    mem_operation <= 2'b11;
                    addr_o        <= wr_addr;
                    data_o        <= res;
                end else if (mem_opdone) begin
                    acc     <= '0;
                    wr_addr <= wr_addr + ADDR_W'(1);
                    c       <= c + XW'(s_eff);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/matrix_convolution_strided.md
Name: matrix_convolution_strided

Overview:
Parametrised successor of the memory-mapped convolution engine. It reads its parameters from RAM and caches the filter internally, so the filter is fetched once rather than per output. It then computes a 2-D convolution with configurable stride and signed/unsigned arithmetic, plus optional ReLU, and writes each result back over the shared single-port memory handshake. It sits on the same memory bus and `enable`/`done` control scheme as the existing accelerators.

Parameters:
DATA_W, 32, width of memory data words and operands
ADDR_W, 32, width of memory word address
PARAM_BASE, 0, word address of the parameter block
MAX_TAPS, 16, filter cache depth; filter height × width must not exceed this
ACC_W, 64, accumulator width; must be at least 2×DATA_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  start request; rising edge starts a job
mem_opdone  in  1  memory completes the current transaction this cycle
data_i  in  DATA_W  read data, valid when mem_opdone=1
data_o  out  DATA_W  write data
addr_o  out  ADDR_W  word address
mem_operation  out  2  00 none, 01 read, 11 write
done  out  1  job finished; held until the next start
error  out  1  last job rejected for bad parameters; valid while done=1
busy  out  1  high from start until done

Behaviour:
- Reset: every output is 0, FSM goes to DONE, and the last_enable register is cleared. Reset mid-job aborts the job immediately and issues no further memory operations.
- Start: only in DONE, when enable=1 and last_enable=0. On start: done←0, error←0, busy←1, go to FETCH_PARAMS. last_enable samples enable every cycle.
- Memory handshake:
  - Drive mem_operation, addr_o and data_o stable until the cycle mem_opdone=1.
  - In that cycle, capture data_i (reads) and set mem_operation←00.
  - At least one idle (00) cycle separates consecutive transactions.
  - mem_opdone while mem_operation=00 is ignored.
- Parameter words, at PARAM_BASE+n:
  - n=0 WA, matrix width
  - n=1 HA, matrix height
  - n=2 WF, filter width
  - n=3 HF, filter height
  - n=4 S, stride; 0 is treated as 1
  - n=5 MODE: bit0 signed, bit1 ReLU; other bits ignored
- Memory layout, all row-major:
  - A at BA = PARAM_BASE+6
  - F at BF = BA + WA·HA
  - R at BR = BF + WF·HF
- CHECK: sets error=1 and goes straight to DONE with no writes if any of these hold:
  - any of WA, HA, WF, HF is 0
  - WF>WA or HF>HA
  - WF·HF > MAX_TAPS
- LOAD_FILTER: reads BF..BF+WF·HF−1 into the cache, in order.
- Output grid:
  - OH = floor((HA−HF)/S)+1, OW = floor((WA−WF)/S)+1.
  - No divider is used: row origin r steps by S while r+HF ≤ HA; column origin c likewise against WA.
  - Output index (oi,oj) increments by 1.
- States: DONE → FETCH_PARAMS → CHECK → LOAD_FILTER → ROW → COL → MAC_READ → MAC → (MAC_READ | WRITE) → COL … → DONE.
- MAC:
  - acc += A[r+k][c+l] · Fcache[k·WF+l].
  - Operands are sign-extended (MODE bit0=1) or zero-extended to ACC_W.
  - Inner loop order: l fastest, then k.
- WRITE:
  - Address BR + oi·OW + oj; data is acc truncated to DATA_W, after ReLU if enabled (signed acc<0 → 0).
  - acc is cleared after mem_opdone.
- Ordering: results are written in row-major output order, exactly OH·OW writes per job.
- Completion: after the last write, done←1, busy←0. enable held high does not retrigger.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.

Optional Feature:
MATCONV_SATURATE_EN
- Defined: before WRITE, acc saturates to the DATA_W range of the active mode.
  - Signed range: [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Unsigned range: [0, 2^DATA_W−1].
  - ReLU is applied after saturation.
- Undefined: plain truncation to the low DATA_W bits.

Test Plan:
- Basic stride 1: PARAM_BASE=0, A=4×4 holding 1..16, F=2×2 [1,0;0,1], S=1, MODE=0 → 9 writes at 26..34 = 7,9,11,15,17,19,23,25,27; then done=1, error=0.
- Stride 2: same data with S=2 → 4 writes at 26..29 = 7,11,23,27; filter read exactly 4 times in total.
- Signed and ReLU: 1×1 A=0xFFFFFFFD, F=5, MODE=1 → writes 0xFFFFFFF1 at address 8. Same job with MODE=3 → writes 0.
- Saturation: 1×1 A=0x7FFFFFFF, F=2, MODE=1 → writes 0x7FFFFFFF with MATCONV_SATURATE_EN, 0xFFFFFFFE without.
- Errors:
  - 2×2 matrix with 3×3 filter → error=1, done=1, no write issued.
  - 5×5 filter on a 5×5 matrix with MAX_TAPS=16 → error=1.
  - HA=0 → error=1.
- Robustness:
  - mem_opdone delayed randomly 0–5 cycles → identical results; addr_o and data_o stable while waiting.
  - Reset asserted mid-MAC → all outputs 0 next cycle, no further mem_operation.
  - A fresh enable rising edge then completes normally.
